jk_cmd_sequencer: RTL and testbench

Command-driven stimulus stage that sits directly upstream of the JK flip-flop DUT and produces its `j`/`k` inputs. It accepts opcode/repeat commands over a valid/ready handshake and buffers them in a small FIFO. It replays each command onto `j`/`k` for a programmed number of cycles, with no bubble between queued commands. It also maintains `q_exp`, a cycle-accurate model of the flip-flop output, for the bench checker.

---
 rtl/jk_seq_pkg.sv | 32 +++
 rtl/jk_cmd_fifo.sv | 58 +++++
 rtl/jk_cmd_sequencer.sv | 111 +++++++++++
 tb/tb_jk_cmd_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_seq_pkg.sv
// Shared opcodes, state encoding and command record for the JK command sequencer.
package jk_seq_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  // Widest repeat count the command record can carry; narrower counts are zero-extended.
  localparam int REP_MAX_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]           op;
    logic [REP_MAX_W-1:0] rep;
  } cmd_t;

  function automatic logic next_q(input logic q, input logic [1:0] jk);
    case (jk)
      OP_HOLD: return q;
      OP_CLR:  return 1'b0;
      OP_SET:  return 1'b1;
      OP_TGL:  return ~q;
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO: count plus wrapping read/write pointers, head is always visible.
module jk_cmd_fifo
  import jk_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  // Full is judged before the edge, so a same-edge pop never frees room for a push.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Replays queued {op, rep} commands onto j/k back to back and tracks the expected flip-flop q.
// state | meaning
// IDLE  | j/k parked at 00, waiting for a queued command
// RUN   | driving op on j/k, cnt counts down the remaining repeats
module jk_cmd_sequencer
  import jk_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_rep,
  output logic             j,
  output logic             k,
  output logic             q_exp,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  cmd_t             cmd_in;
  cmd_t             head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign cmd_in    = '{op: cmd_op, rep: REP_MAX_W'(cmd_rep)};
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  // Pop whenever the FSM is ready for a new command: idle, or on the last cycle of the current one.
  assign pop       = !flush && !empty && (state == IDLE || cnt == '0);
  assign busy      = (state == RUN) || !empty;

  jk_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (cmd_in),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  if (CNT_W < REP_MAX_W) begin : g_rep_hi
    logic unused_rep_hi;
    assign unused_rep_hi = ^head.rep[REP_MAX_W-1:CNT_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
      q_exp <= 1'b0;
      done  <= 1'b0;
    end else begin
      // q_exp follows the same registered j/k the DUT samples, flush edge included.
      q_exp <= next_q(q_exp, {j, k});
      done  <= 1'b0;
      if (flush) begin
        state <= IDLE;
        cnt   <= '0;
        j     <= 1'b0;
        k     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            j <= 1'b0;
            k <= 1'b0;
            if (!empty) begin
              {j, k} <= head.op;
              cnt    <= head.rep[CNT_W-1:0];
              state  <= RUN;
            end
          end
          RUN: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (!empty) begin
              {j, k} <= head.op;
              cnt    <= head.rep[CNT_W-1:0];
            end else begin
              j     <= 1'b0;
              k     <= 1'b0;
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            j     <= 1'b0;
            k     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: directed scenarios plus a random run against a queue model.
module tb_jk_cmd_sequencer;
  import jk_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_rep = '0;
  logic             cmd_ready;
  logic             j;
  logic             k;
  logic             q_exp;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending commands, cycles left in the active one, and the expected outputs.
  logic [5:0] mq[$];
  int         m_left;
  logic       m_j, m_k, m_q, m_done;

  always #5 clk = ~clk;

  jk_cmd_sequencer #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rep   (cmd_rep),
    .j         (j),
    .k         (k),
    .q_exp     (q_exp),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [4:0] model_vec();
    return {m_j, m_k, m_q, m_done, (m_left > 0) || (mq.size() > 0)};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_left = 0;
    m_j = 1'b0;
    m_k = 1'b0;
    m_q = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_edge();
    bit         was_empty;
    bit         was_run;
    bit         acc;
    logic [5:0] c;
    was_empty = (mq.size() == 0);
    was_run   = (m_left > 0);
    acc       = cmd_valid && (mq.size() < DEPTH) && !flush;
    if ({m_j, m_k} == 2'b01) m_q = 1'b0;
    else if ({m_j, m_k} == 2'b10) m_q = 1'b1;
    else if ({m_j, m_k} == 2'b11) m_q = ~m_q;
    m_done = 1'b0;
    if (flush) begin
      mq.delete();
      m_left = 0;
      m_j = 1'b0;
      m_k = 1'b0;
    end else begin
      if (was_run) m_left--;
      if (m_left == 0) begin
        if (!was_empty) begin
          c = mq.pop_front();
          {m_j, m_k} = c[5:4];
          m_left = int'(c[3:0]) + 1;
        end else begin
          if (was_run) m_done = 1'b1;
          m_j = 1'b0;
          m_k = 1'b0;
        end
      end
      if (acc) mq.push_back({cmd_op, cmd_rep});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    n_checks++;
    if ({j, k, q_exp, done, busy, cmd_ready} !== 6'b000001) begin
      n_errors++;
      $display("FAIL reset_hold: {j,k,q_exp,done,busy,cmd_ready} got %b want 000001",
               {j, k, q_exp, done, busy, cmd_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({j, k, q_exp, done, busy, cmd_ready} !== 6'b000001) begin
      n_errors++;
      $display("FAIL reset_idle: {j,k,q_exp,done,busy,cmd_ready} got %b want 000001",
               {j, k, q_exp, done, busy, cmd_ready});
    end
  endtask

  task automatic test_set_rep2();
    logic [4:0] exp_t [0:5];
    exp_t = '{5'b00001, 5'b10001, 5'b10101, 5'b10101, 5'b00110, 5'b00100};
    do_reset();
    cmd_valid = 1'b1;
    cmd_op = OP_SET;
    cmd_rep = 4'd2;
    for (int c = 0; c < 6; c++) begin
      tick();
      cmd_valid = 1'b0;
      n_checks++;
      if ({j, k, q_exp, done, busy} !== exp_t[c]) begin
        n_errors++;
        $display("FAIL set_rep2 t%0d: {j,k,q_exp,done,busy} got %b want %b",
                 c, {j, k, q_exp, done, busy}, exp_t[c]);
      end
    end
  endtask

  task automatic test_toggle();
    logic [4:0] exp_t [0:6];
    exp_t = '{5'b00001, 5'b11001, 5'b11101, 5'b11001, 5'b11101, 5'b00010, 5'b00000};
    do_reset();
    cmd_valid = 1'b1;
    cmd_op = OP_TGL;
    cmd_rep = 4'd3;
    for (int c = 0; c < 7; c++) begin
      tick();
      cmd_valid = 1'b0;
      n_checks++;
      if ({j, k, q_exp, done, busy} !== exp_t[c]) begin
        n_errors++;
        $display("FAIL toggle t%0d: {j,k,q_exp,done,busy} got %b want %b",
                 c, {j, k, q_exp, done, busy}, exp_t[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_t [0:6];
    logic [1:0] ops   [0:2];
    logic [3:0] reps  [0:2];
    exp_t = '{5'b00001, 5'b10001, 5'b01101, 5'b01001, 5'b11001, 5'b00110, 5'b00100};
    ops   = '{OP_SET, OP_CLR, OP_TGL};
    reps  = '{4'd0, 4'd1, 4'd0};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cmd_valid = (c < 3);
      if (c < 3) begin
        cmd_op = ops[c];
        cmd_rep = reps[c];
      end
      tick();
      n_checks++;
      if ({j, k, q_exp, done, busy} !== exp_t[c]) begin
        n_errors++;
        $display("FAIL back_to_back t%0d: {j,k,q_exp,done,busy} got %b want %b",
                 c, {j, k, q_exp, done, busy}, exp_t[c]);
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_full();
    int edge_idx;
    bit acc;
    do_reset();
    cmd_valid = 1'b1;
    cmd_op = OP_SET;
    cmd_rep = 4'd15;
    tick();
    edge_idx = 0;
    for (int p = 0; p < 4; p++) begin
      cmd_op = 2'($urandom_range(0, 3));
      cmd_rep = 4'($urandom_range(0, 3));
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL full_fill push%0d: cmd_ready got %b want 1", p, cmd_ready);
      end
      tick();
      edge_idx++;
    end
    cmd_op = OP_CLR;
    cmd_rep = 4'd1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL full_ready: cmd_ready got %b want 0", cmd_ready);
    end
    acc = 1'b0;
    for (int c = 0; c < 40 && !acc; c++) begin
      acc = (mq.size() < DEPTH);
      n_checks++;
      if (cmd_ready !== acc) begin
        n_errors++;
        $display("FAIL full_wait edge%0d: cmd_ready got %b want %b", edge_idx + 1, cmd_ready, acc);
      end
      tick();
      edge_idx++;
      n_checks++;
      if ({j, k, q_exp, done, busy} !== model_vec()) begin
        n_errors++;
        $display("FAIL full_wait_out edge%0d: {j,k,q_exp,done,busy} got %b want %b",
                 edge_idx, {j, k, q_exp, done, busy}, model_vec());
      end
    end
    n_checks++;
    if (!acc || edge_idx != 18) begin
      n_errors++;
      $display("FAIL full_accept_edge: accepted=%0b at edge %0d want accepted at edge 18", acc, edge_idx);
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 100 && model_vec() != 5'b0; c++) begin
      tick();
      n_checks++;
      if ({j, k, q_exp, done, busy} !== model_vec()) begin
        n_errors++;
        $display("FAIL full_drain c%0d: {j,k,q_exp,done,busy} got %b want %b",
                 c, {j, k, q_exp, done, busy}, model_vec());
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    cmd_valid = 1'b1;
    cmd_op = OP_TGL;
    cmd_rep = 4'd7;
    tick();
    cmd_op = OP_SET;
    cmd_rep = 4'd1;
    tick();
    cmd_op = OP_CLR;
    cmd_rep = 4'd2;
    tick();
    cmd_valid = 1'b0;
    tick();
    n_checks++;
    if ({j, k, q_exp, done, busy} !== 5'b11001) begin
      n_errors++;
      $display("FAIL flush_pre: {j,k,q_exp,done,busy} got %b want 11001", {j, k, q_exp, done, busy});
    end
    flush = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = OP_SET;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_ready: cmd_ready got %b want 0", cmd_ready);
    end
    tick();
    flush = 1'b0;
    cmd_valid = 1'b0;
    n_checks++;
    if ({j, k, q_exp, done, busy} !== 5'b00100) begin
      n_errors++;
      $display("FAIL flush_edge: {j,k,q_exp,done,busy} got %b want 00100", {j, k, q_exp, done, busy});
    end
    tick();
    n_checks++;
    if ({j, k, q_exp, done, busy} !== 5'b00100) begin
      n_errors++;
      $display("FAIL flush_after: {j,k,q_exp,done,busy} got %b want 00100", {j, k, q_exp, done, busy});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cmd_valid = 1'b1;
    cmd_op = OP_TGL;
    cmd_rep = 4'd10;
    tick();
    cmd_op = OP_SET;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({j, k, q_exp, done, busy, cmd_ready} !== 6'b000001) begin
      n_errors++;
      $display("FAIL async_reset: {j,k,q_exp,done,busy,cmd_ready} got %b want 000001",
               {j, k, q_exp, done, busy, cmd_ready});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({j, k, q_exp, done, busy} !== 5'b00000) begin
      n_errors++;
      $display("FAIL async_reset_lost: {j,k,q_exp,done,busy} got %b want 00000", {j, k, q_exp, done, busy});
    end
  endtask

  task automatic test_random();
    bit exp_ready;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op = 2'($urandom_range(0, 3));
      cmd_rep = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      flush = ($urandom_range(0, 59) == 0);
      #1;
      exp_ready = (mq.size() < DEPTH) && !flush;
      n_checks++;
      if (cmd_ready !== exp_ready) begin
        n_errors++;
        $display("FAIL random_ready c%0d: cmd_ready got %b want %b", c, cmd_ready, exp_ready);
      end
      tick();
      n_checks++;
      if ({j, k, q_exp, done, busy} !== model_vec()) begin
        n_errors++;
        $display("FAIL random_out c%0d: {j,k,q_exp,done,busy} got %b want %b",
                 c, {j, k, q_exp, done, busy}, model_vec());
      end
    end
    cmd_valid = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_set_rep2();
    test_toggle();
    test_back_to_back();
    test_full();
    test_flush();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
